// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared async-FIFO constants and Gray/binary helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int ADDRSIZEL_DEFAULT = 4;
    localparam int PTR_MAX_W         = 32;

    // Callers zero-extend narrower pointers; the leading zeros do not disturb
    // the low-order result bits, so one function body covers every width.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        logic                 acc;
        bin = '0;
        acc = 1'b0;
        for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray2bin_conv.sv
`default_nettype none
// ============================================================================
// Module      : gray2bin_conv
// Description : Combinational Gray-to-binary converter (MSB-first XOR prefix).
// Revision    : 1.0 - initial release
// ============================================================================
module gray2bin_conv #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic acc;

    always_comb begin
        bin = '0;
        acc = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rptr_empty.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rptr_empty
// Description : Async-FIFO read pointer (binary + Gray) with registered empty
//               and underflow flags. Define RPTR_LEVEL_EN to add rlevel and
//               ralmost_empty outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDRSIZEL = ADDRSIZEL_DEFAULT,
    parameter int AE_THRESH = 2
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 rinc,
    input  logic [ADDRSIZEL:0]   rq2_wptr,
    output logic [ADDRSIZEL-1:0] raddr,
    output logic [ADDRSIZEL:0]   rptr,
    output logic                 rempty,
`ifdef RPTR_LEVEL_EN
    output logic [ADDRSIZEL:0]   rlevel,
    output logic                 ralmost_empty,
`endif
    output logic                 runderflow
);

    localparam int PW = ADDRSIZEL + 1;

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          rempty_q, rempty_d;
    logic          runderflow_q, runderflow_d;

    always_comb begin
        rbin_d       = rbin_q + PW'(rinc & ~rempty_q);
        rptr_d       = PW'(bin2gray(PTR_MAX_W'(rbin_d)));
        // Comparing the next pointer lets the flag rise on the consuming edge.
        rempty_d     = (rptr_d == rq2_wptr);
        runderflow_d = rinc & rempty_q;
    end

`ifdef RPTR_LEVEL_EN
    localparam logic [31:0] AE_THRESH_U = 32'(AE_THRESH);

    logic [PW-1:0] wbin_s;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          ralmost_empty_q, ralmost_empty_d;

    gray2bin_conv #(
        .WIDTH (PW)
    ) u_wptr_g2b (
        .gray (rq2_wptr),
        .bin  (wbin_s)
    );

    // Synchronized write pointer lags the writer, so this never overstates.
    always_comb begin
        rlevel_d        = wbin_s - rbin_d;
        ralmost_empty_d = (32'(rlevel_d) <= AE_THRESH_U);
    end
`else
    logic unused_ae_thresh;
    assign unused_ae_thresh = ^AE_THRESH;
`endif

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q          <= '0;
            rptr_q          <= '0;
            rempty_q        <= 1'b1;
            runderflow_q    <= 1'b0;
`ifdef RPTR_LEVEL_EN
            rlevel_q        <= '0;
            ralmost_empty_q <= 1'b1;
`endif
        end else begin
            rbin_q          <= rbin_d;
            rptr_q          <= rptr_d;
            rempty_q        <= rempty_d;
            runderflow_q    <= runderflow_d;
`ifdef RPTR_LEVEL_EN
            rlevel_q        <= rlevel_d;
            ralmost_empty_q <= ralmost_empty_d;
`endif
        end
    end

    assign raddr      = rbin_q[ADDRSIZEL-1:0];
    assign rptr       = rptr_q;
    assign rempty     = rempty_q;
    assign runderflow = runderflow_q;
`ifdef RPTR_LEVEL_EN
    assign rlevel        = rlevel_q;
    assign ralmost_empty = ralmost_empty_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rptr_empty.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rptr_empty
// Description : Directed self-checking bench for fifo_rptr_empty (ADDRSIZEL=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rptr_empty;

    localparam int AW = 4;

    logic          rclk;
    logic          rrst_n;
    logic          rinc;
    logic [AW:0]   rq2_wptr;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic          runderflow;
`ifdef RPTR_LEVEL_EN
    logic [AW:0]   rlevel;
    logic          ralmost_empty;
`endif

    int tests = 0;
    int fails = 0;

    fifo_rptr_empty #(
        .ADDRSIZEL (AW),
        .AE_THRESH (2)
    ) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .rinc          (rinc),
        .rq2_wptr      (rq2_wptr),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
`ifdef RPTR_LEVEL_EN
        .rlevel        (rlevel),
        .ralmost_empty (ralmost_empty),
`endif
        .runderflow    (runderflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [AW:0] g(input int b);
        logic [AW:0] v;
        v = AW'(0);
        v = (AW+1)'(b);
        return (v >> 1) ^ v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rempty"}, 32'(rempty), 32'd1);
        check({tag, "_rptr"}, 32'(rptr), 32'd0);
        check({tag, "_raddr"}, 32'(raddr), 32'd0);
        check({tag, "_runderflow"}, 32'(runderflow), 32'd0);
`ifdef RPTR_LEVEL_EN
        check({tag, "_rlevel"}, 32'(rlevel), 32'd0);
        check({tag, "_ralmost_empty"}, 32'(ralmost_empty), 32'd1);
`endif
    endtask

    initial begin
        int          rb;
        logic [AW:0] prev;

        // Reset
        rrst_n   = 1'b0;
        rinc     = 1'b0;
        rq2_wptr = '0;
        #22;
        check_reset_state("reset");
        @(negedge rclk);
        rrst_n = 1'b1;
        tick();
        check("idle_rempty", 32'(rempty), 32'd1);

        // One entry becomes visible, then is read
        rq2_wptr = 5'b00001;
        tick();
        check("one_rempty", 32'(rempty), 32'd0);
`ifdef RPTR_LEVEL_EN
        check("one_rlevel", 32'(rlevel), 32'd1);
        check("one_ae", 32'(ralmost_empty), 32'd1);
`endif
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        check("rd1_rptr", 32'(rptr), 32'b00001);
        check("rd1_raddr", 32'(raddr), 32'd1);
        check("rd1_rempty", 32'(rempty), 32'd1);
        check("rd1_runderflow", 32'(runderflow), 32'd0);

        // Write pointer jumps 16 entries ahead (binary 17, Gray 11001)
        rb = 1;
        rq2_wptr = 5'b11001;
        tick();
        check("full_rempty", 32'(rempty), 32'd0);
`ifdef RPTR_LEVEL_EN
        check("full_rlevel", 32'(rlevel), 32'd16);
        check("full_ae", 32'(ralmost_empty), 32'd0);
`endif
        rinc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            rb++;
            check("drain_rptr", 32'(rptr), 32'(g(rb)));
            check("drain_raddr", 32'(raddr), 32'(rb % 16));
            check("drain_rempty", 32'(rempty), 32'(k == 16));
            check("drain_runderflow", 32'(runderflow), 32'd0);
`ifdef RPTR_LEVEL_EN
            check("drain_rlevel", 32'(rlevel), 32'(16 - k));
            check("drain_ae", 32'(ralmost_empty), 32'(k >= 14));
`endif
            if (k == 15) check("wrap_rptr", 32'(rptr), 32'b11000);
        end
        check("drained_rptr", 32'(rptr), 32'b11001);

        // Underflow: rinc held while empty
        for (int k = 0; k < 3; k++) begin
            tick();
            check("uf_pulse", 32'(runderflow), 32'd1);
            check("uf_rptr", 32'(rptr), 32'b11001);
            check("uf_rempty", 32'(rempty), 32'd1);
        end
        rinc = 1'b0;
        tick();
        check("uf_clear", 32'(runderflow), 32'd0);

        // Pointer chase, write pointer kept 3 ahead
        rq2_wptr = g(rb + 3);
        tick();
        check("chase_start_rempty", 32'(rempty), 32'd0);
        rinc = 1'b1;
        for (int k = 0; k < 51; k++) begin
            prev     = rptr;
            rq2_wptr = g(rb + 4);
            tick();
            rb++;
            check("chase_rempty", 32'(rempty), 32'd0);
            check("chase_rptr", 32'(rptr), 32'(g(rb)));
            check("chase_onebit", 32'($countones(prev ^ rptr)), 32'd1);
`ifdef RPTR_LEVEL_EN
            check("chase_rlevel", 32'(rlevel), 32'd3);
`endif
        end
        rinc = 1'b0;
        check("mid_rptr", 32'(rptr), 32'b00110);

        // Asynchronous reset mid-cycle, no clock edge in between
        #3;
        rrst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(negedge rclk);
        rrst_n = 1'b1;
        tick();
        check("post_reset_rempty", 32'(rempty), 32'd0);
        check("post_reset_rptr", 32'(rptr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
